// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared state encoding and ASCII constants for the memory dump reader
package mem_dump_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int CHARS_PER_WORD = 8;
endpackage

// File: rtl/hex_ascii.sv
// hex_ascii: combinational nibble to uppercase hex ASCII converter
module hex_ascii
  import mem_dump_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);
  assign asc = (nib < 4'd10) ? ASCII_0 + {4'd0, nib} : ASCII_A + {4'd0, nib} - 8'd10;
endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: dumps a window of data-memory words as hex ASCII into the display buffer
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'd133,
  parameter int         N_WORDS   = 8
) (
  input  logic        sysclk,
  input  logic        cpu_resetn,
  input  logic        start,
  output logic [7:0]  mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        disp_we,
  output logic [5:0]  disp_addr,
  output logic [7:0]  disp_data,
  output logic        busy,
  output logic        done
);
  logic [2:0]  state_q, state_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  w_q, w_d, n_q, n_d;
  logic        disp_we_q, disp_we_d;
  logic [5:0]  disp_addr_q, disp_addr_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [4:0]  sh;
  logic [7:0]  asc;
  assign sh = 5'd28 - {n_q, 2'b00};
  hex_ascii u_hex (.nib(word_q[sh +: 4]), .asc(asc));
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    word_d      = word_q;
    w_d         = w_q;
    n_d         = n_q;
    disp_we_d   = 1'b0;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d    = S_READ;
        mem_addr_d = BASE_ADDR;
        w_d        = '0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        word_d  = mem_rdata;
        n_d     = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        disp_we_d   = 1'b1;
        disp_addr_d = {w_q, n_q};
        disp_data_d = asc;
        n_d         = n_q + 3'd1;
        if (n_q == 3'(CHARS_PER_WORD - 1)) begin
          if (w_q != 3'(N_WORDS - 1)) begin
            w_d        = w_q + 3'd1;
            mem_addr_d = mem_addr_q + 8'd1;
            state_d    = S_READ;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= BASE_ADDR;
      word_q      <= '0;
      w_q         <= '0;
      n_q         <= '0;
      disp_we_q   <= 1'b0;
      disp_addr_q <= '0;
      disp_data_q <= ASCII_SPACE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      word_q      <= word_d;
      w_q         <= w_d;
      n_q         <= n_d;
      disp_we_q   <= disp_we_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign mem_addr  = mem_addr_q;
  assign disp_we   = disp_we_q;
  assign disp_addr = disp_addr_q;
  assign disp_data = disp_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: directed checks of three dump reader configurations
module tb_mem_dump_reader;
  logic        sysclk = 1'b0;
  logic        cpu_resetn;
  logic        start;
  logic [7:0]  maddr [3];
  logic [31:0] rdata [3];
  logic        we    [3];
  logic [5:0]  da    [3];
  logic [7:0]  dd    [3];
  logic        bsy   [3];
  logic        dn    [3];
  logic [31:0] mem   [3][256];
  logic [7:0]  disp  [3][64];
  int          nstb  [3];
  int          last  [3];
  int          cyc = 0;
  int          e0 = 0;
  int          checks = 0;
  int          errors = 0;
  int          blank;
  logic [7:0]  exp_b [8] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h33, 8'h31, 8'h35};
  always #5 sysclk = ~sysclk;
  mem_dump_reader #(.BASE_ADDR(8'd133), .N_WORDS(8)) u_a (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .start(start), .mem_addr(maddr[0]), .mem_rdata(rdata[0]),
    .disp_we(we[0]), .disp_addr(da[0]), .disp_data(dd[0]), .busy(bsy[0]), .done(dn[0]));
  mem_dump_reader #(.BASE_ADDR(8'd133), .N_WORDS(1)) u_b (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .start(start), .mem_addr(maddr[1]), .mem_rdata(rdata[1]),
    .disp_we(we[1]), .disp_addr(da[1]), .disp_data(dd[1]), .busy(bsy[1]), .done(dn[1]));
  mem_dump_reader #(.BASE_ADDR(8'd254), .N_WORDS(3)) u_c (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .start(start), .mem_addr(maddr[2]), .mem_rdata(rdata[2]),
    .disp_we(we[2]), .disp_addr(da[2]), .disp_data(dd[2]), .busy(bsy[2]), .done(dn[2]));
  always @(posedge sysclk) begin
    rdata[0] <= mem[0][maddr[0]];
    rdata[1] <= mem[1][maddr[1]];
    rdata[2] <= mem[2][maddr[2]];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++)
      if (we[k] === 1'b1) begin
        disp[k][da[k]] = dd[k];
        nstb[k]++;
        last[k] = cyc;
      end
  endtask
  task automatic clr();
    for (int k = 0; k < 3; k++) begin
      nstb[k] = 0;
      last[k] = 0;
      for (int i = 0; i < 64; i++) disp[k][i] = 8'h00;
    end
  endtask
  function automatic logic [63:0] hexstr(input logic [31:0] v);
    string s;
    logic [63:0] r;
    s = $sformatf("%08h", v);
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = (s[i] >= "a") ? 8'(s[i] - 8'd32) : 8'(s[i]);
    return r;
  endfunction
  function automatic logic [63:0] cells(input int k, input int w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = disp[k][w*8+i];
    return r;
  endfunction
  initial begin
    cpu_resetn = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 256; i++) mem[k][i] = 32'h11111111 * 32'(k + 1);
    mem[0][133] = 32'h89ABCDEF; mem[0][134] = 32'h00000037;
    mem[0][135] = 32'h12345678; mem[0][136] = 32'h9ABCDEF0;
    mem[0][137] = 32'hDEADBEEF; mem[0][138] = 32'h0F1E2D3C;
    mem[0][139] = 32'h4B5A6978; mem[0][140] = 32'h87654321;
    mem[1][133] = 32'h00000315;
    mem[2][254] = 32'hCAFEF00D; mem[2][255] = 32'h01234567; mem[2][0] = 32'h76543210;
    clr();
    tick();
    tick();
    chk("rst_a_addr", 64'(maddr[0]), 64'd133);
    chk("rst_c_addr", 64'(maddr[2]), 64'd254);
    chk("rst_we", 64'(we[0]), 64'd0);
    chk("rst_daddr", 64'(da[0]), 64'd0);
    chk("rst_ddata", 64'(dd[0]), 64'h20);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_done", 64'(dn[0]), 64'd0);
    #2 cpu_resetn = 1'b1;
    tick();
    clr();
    start = 1'b1;
    tick();
    e0 = cyc;
    start = 1'b0;
    chk("a_addr_e0", 64'(maddr[0]), 64'd133);
    chk("a_busy_e0", 64'(bsy[0]), 64'd1);
    chk("c_addr_e0", 64'(maddr[2]), 64'd254);
    for (int t = 1; t <= 82; t++) begin
      start = (t == 5);
      tick();
      if (t <= 11) chk("b_we", 64'(we[1]), 64'(t >= 3 && t <= 10));
      if (t >= 3 && t <= 10) begin
        chk("b_daddr", 64'(da[1]), 64'(t - 3));
        chk("b_ddata", 64'(dd[1]), 64'(exp_b[t-3]));
      end
      if (t == 2) chk("a_we_t2", 64'(we[0]), 64'd0);
      if (t == 3) chk("a_we_t3", 64'(we[0]), 64'd1);
      if (t == 5) chk("a_busy_ign", 64'(bsy[0]), 64'd1);
      if (t == 10) begin
        chk("b_done", 64'(dn[1]), 64'd1);
        chk("b_busy", 64'(bsy[1]), 64'd0);
        chk("c_addr_w1", 64'(maddr[2]), 64'd255);
        chk("a_addr_w1", 64'(maddr[0]), 64'd134);
      end
      if (t == 20) chk("c_addr_w2", 64'(maddr[2]), 64'd0);
      if (t == 30) chk("c_done", 64'(dn[2]), 64'd1);
      if (t == 79) chk("a_done_early", 64'(dn[0]), 64'd0);
      if (t == 80) begin
        chk("a_we_last", 64'(we[0]), 64'd1);
        chk("a_daddr_last", 64'(da[0]), 64'd63);
        chk("a_done", 64'(dn[0]), 64'd1);
        chk("a_busy_end", 64'(bsy[0]), 64'd0);
      end
      if (t == 81) chk("a_we_off", 64'(we[0]), 64'd0);
    end
    start = 1'b0;
    chk("a_strobes", 64'(nstb[0]), 64'd64);
    chk("a_last_edge", 64'(last[0]), 64'(e0 + 80));
    chk("b_strobes", 64'(nstb[1]), 64'd8);
    chk("c_strobes", 64'(nstb[2]), 64'd24);
    for (int w = 0; w < 8; w++) chk($sformatf("a_word%0d", w), cells(0, w), hexstr(mem[0][133+w]));
    chk("c_word0", cells(2, 0), hexstr(32'hCAFEF00D));
    chk("c_word1", cells(2, 1), hexstr(32'h01234567));
    chk("c_word2", cells(2, 2), hexstr(32'h76543210));
    blank = 0;
    for (int i = 8; i < 64; i++) if (disp[1][i] != 8'h00) blank++;
    chk("b_untouched", 64'(blank), 64'd0);
    clr();
    start = 1'b1;
    tick();
    e0 = cyc;
    chk("re_busy", 64'(bsy[0]), 64'd1);
    chk("re_done", 64'(dn[0]), 64'd0);
    chk("re_addr", 64'(maddr[0]), 64'd133);
    for (int t = 1; t <= 25; t++) tick();
    start = 1'b0;
    chk("mid_we", 64'(we[0]), 64'd1);
    chk("mid_addr", 64'(maddr[0]), 64'd135);
    #2 cpu_resetn = 1'b0;
    #1;
    chk("arst_addr", 64'(maddr[0]), 64'd133);
    chk("arst_we", 64'(we[0]), 64'd0);
    chk("arst_daddr", 64'(da[0]), 64'd0);
    chk("arst_ddata", 64'(dd[0]), 64'h20);
    chk("arst_busy", 64'(bsy[0]), 64'd0);
    #2 cpu_resetn = 1'b1;
    tick();
    mem[0][133] = 32'h0000A5C3;
    clr();
    start = 1'b1;
    tick();
    e0 = cyc;
    start = 1'b0;
    chk("post_addr", 64'(maddr[0]), 64'd133);
    for (int t = 1; t <= 10; t++) tick();
    chk("post_word0", cells(0, 0), hexstr(32'h0000A5C3));
    chk("post_strobes", 64'(nstb[0]), 64'd8);
    chk("post_last", 64'(last[0]), 64'(e0 + 10));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
